rs_stream_ctrl: RTL
===================

RS_STREAM_CTRL -- requirements
Module: rs_stream_ctrl

Interface
REQ-001 Parameter MSG_BYTES, default 4, is the number of message bytes per codeword (SYMBOL_WIDTH*K/8).
REQ-002 Parameter CW_BYTES, default 5, is the number of codeword bytes (SYMBOL_WIDTH*N/8).
REQ-003 Clock and reset: one clock; reset is synchronous and active-high.
REQ-004 clk  in  1  block clock; all state changes on its rising edge.
REQ-005 rst  in  1  synchronous active-high reset.
REQ-006 in_valid  in  1  message byte present on in_data.
REQ-007 in_ready  out  1  block accepts a message byte this cycle.
REQ-008 in_data  in  8  message byte; the first byte of a message is the most significant.
REQ-009 flush  in  1  discards a partially collected message.
REQ-010 out_valid  out  1  a codeword byte is present on out_data.
REQ-011 out_ready  in  1  downstream accepts a codeword byte.
REQ-012 out_data  out  8  codeword byte; the most significant byte goes first.
REQ-013 out_first  out  1  marks codeword byte 0 while out_valid is high.
REQ-014 busy  out  1  high in any state other than COLLECT with zero bytes held.
REQ-015 cw_count  out  16  count of completely emitted codewords.

Function
REQ-016 The FSM SHALL have three states: COLLECT, ENCODE and EMIT.
REQ-017 COLLECT SHALL behave as follows:
- in_ready = !flush.
- An input byte is accepted when in_valid && in_ready.
- Accepted byte i (0-based) is written to msg[8*(MSG_BYTES-i)-1 -: 8].
- The byte index increments on each accepted byte.
REQ-018 On acceptance of byte MSG_BYTES-1, the FSM SHALL go to ENCODE and the byte index SHALL clear.
REQ-019 ENCODE SHALL last exactly one cycle:
- in_ready = 0 and out_valid = 0.
- The encoder output is registered into cw[8*CW_BYTES-1:0].
- The next state is EMIT.
REQ-020 EMIT SHALL behave as follows:
- out_valid = 1 and in_ready = 0.
- out_data = cw byte j, where j=0 is cw[39:32] and j=4 is cw[7:0].
- out_first = (j == 0).
REQ-021 A transfer in EMIT is out_valid && out_ready; each transfer SHALL increment j.
REQ-022 On the transfer of byte CW_BYTES-1, the FSM SHALL:
- go to COLLECT;
- clear j;
- increment cw_count.
REQ-023 cw_count SHALL wrap from 0xFFFF to 0x0000.
REQ-024 When out_ready is low in EMIT, out_data and out_first SHALL hold stable and j SHALL not change.
REQ-025 Latency: the first codeword byte SHALL be valid 2 cycles after the cycle in which the last message byte is accepted.
REQ-026 Best-case throughput is 1 codeword per MSG_BYTES+1+CW_BYTES cycles; input and output phases do not overlap.
REQ-027 flush high in COLLECT SHALL clear the byte index and msg, and no byte is accepted in that cycle (flush wins over in_valid).
REQ-028 flush in ENCODE or EMIT SHALL be ignored; the codeword in flight always completes.
REQ-029 The codeword SHALL be systematic: cw[39:8] equals msg, and cw[7:0] is the parity produced by the encoder instance.
REQ-030 The parity SHALL be linear over GF(2): parity(a^b) = parity(a) ^ parity(b).

Reset
REQ-031 With rst high at a clock edge, the following SHALL result:
- state = COLLECT;
- byte index = 0, j = 0;
- msg = 0, cw = 0;
- cw_count = 0.
REQ-032 The output values in reset SHALL be:
- in_ready = 1 after the edge;
- out_valid = 0, out_first = 0, out_data = 0x00;
- busy = 0.
REQ-033 rst asserted mid-message or mid-emission SHALL abandon the codeword without incrementing cw_count; rst has priority over all other inputs.

Structure
REQ-034 SYMBOL_WIDTH, N, K, MSG_BYTES, CW_BYTES and the state encoding SHALL live in shared package rs_pkg.
REQ-035 The block SHALL instantiate exactly one sub-module, the combinational RS_Encoder (32-bit in, 40-bit out), fed from msg.
REQ-036 No other arithmetic SHALL be duplicated in this block.

Verification
REQ-037 Zero message: in bytes 00 00 00 00 -> out 00 00 00 00 00, out_first on the first byte only, cw_count = 1.
REQ-038 MSB message: in 80 00 00 00 -> out 80 00 00 00 7A; in 00 00 00 01 -> out 00 00 00 01 A3.
REQ-039 Linearity: in 80 00 00 01 -> out 80 00 00 01 D9.
REQ-040 Backpressure: in 80 00 00 00 with out_ready low for 3 cycles at byte j=2 -> out_data holds 00 during the stall, and the full sequence 80 00 00 00 7A is delivered unchanged.
REQ-041 Flush and reset:
- Send 2 bytes, flush together with in_valid on the 3rd, then send 00 00 00 01 -> a single codeword 00 00 00 01 A3.
- rst during EMIT -> out_valid = 0 next cycle, cw_count unchanged at 0.
REQ-042 Counter wrap: preload by running 65536 zero codewords -> cw_count returns to 0x0000.

Source files
------------

// File: rtl/rs_pkg.sv
// Shared Reed-Solomon stream parameters, state encoding and GF(2^8) helper.
package rs_pkg;

  localparam int SYMBOL_WIDTH = 8;
  localparam int N            = 5;
  localparam int K            = 4;
  localparam int MSG_BYTES    = SYMBOL_WIDTH * K / 8;
  localparam int CW_BYTES     = SYMBOL_WIDTH * N / 8;

  // Field polynomial x^8+x^4+x^3+x^2+1, low byte only; x^8 is implied.
  localparam logic [7:0] GF_POLY = 8'h1D;

  // Check-symbol weight for each message byte, first (most significant) byte leftmost.
  localparam logic [8*MSG_BYTES-1:0] PARITY_COEF = 32'h8A5B36A3;

  typedef enum logic [1:0] {
    ST_COLLECT = 2'd0,
    ST_ENCODE  = 2'd1,
    ST_EMIT    = 2'd2
  } state_e;

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? GF_POLY : 8'h00);
    end
    return p;
  endfunction

endpackage

// File: rtl/rs_encoder.sv
// Combinational systematic encoder: message bytes pass through, one check
// symbol is appended as a GF(2^8) weighted sum of the message bytes.
module rs_encoder
  import rs_pkg::*;
(
  input  logic [8*MSG_BYTES-1:0] msg,
  output logic [8*CW_BYTES-1:0]  cw
);

  logic [7:0] parity;

  always_comb begin
    parity = 8'h00;
    for (int i = 0; i < MSG_BYTES; i++) begin
      parity = parity ^ gf_mul(msg[8*(MSG_BYTES-i)-1 -: 8],
                               PARITY_COEF[8*(MSG_BYTES-i)-1 -: 8]);
    end
  end

  assign cw = {msg, parity};

endmodule

// File: rtl/rs_stream_ctrl.sv
// Byte-stream wrapper around rs_encoder: collects a message, encodes it in one
// cycle, then streams the codeword MSB-first under out_ready backpressure.
//
//   state      | meaning
//   COLLECT    | accepting message bytes, flush discards a partial message
//   ENCODE     | one cycle, encoder output captured into cw_q
//   EMIT       | codeword bytes presented on out_data, flush ignored
module rs_stream_ctrl
  import rs_pkg::*;
#(
  parameter int MSG_BYTES = rs_pkg::MSG_BYTES,
  parameter int CW_BYTES  = rs_pkg::CW_BYTES
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  in_data,
  input  logic        flush,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [7:0]  out_data,
  output logic        out_first,
  output logic        busy,
  output logic [15:0] cw_count
);

  localparam int MSG_W = 8 * MSG_BYTES;
  localparam int CW_W  = 8 * CW_BYTES;
  localparam int IDX_W = $clog2(MSG_BYTES);
  localparam int J_W   = $clog2(CW_BYTES);

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [J_W-1:0]     j_q, j_d;
  logic [MSG_W-1:0]   msg_q, msg_d;
  logic [CW_W-1:0]    cw_q, cw_d;
  logic [15:0]        cw_count_q, cw_count_d;
  logic               out_valid_q, out_valid_d;
  logic               out_first_q, out_first_d;
  logic [7:0]         out_data_q, out_data_d;
  logic               busy_q, busy_d;

  logic [CW_W-1:0]    enc_cw;
  logic [J_W-1:0]     j_next;
  logic [7:0]         cw_byte_next;

  rs_encoder u_enc (
    .msg (msg_q),
    .cw  (enc_cw)
  );

  assign in_ready  = (state_q == ST_COLLECT) && !flush;
  assign out_valid = out_valid_q;
  assign out_first = out_first_q;
  assign out_data  = out_data_q;
  assign busy      = busy_q;
  assign cw_count  = cw_count_q;

  assign j_next = j_q + J_W'(1);

  always_comb begin
    cw_byte_next = 8'h00;
    for (int k = 0; k < CW_BYTES; k++) begin
      if (j_next == J_W'(k)) cw_byte_next = cw_q[8*(CW_BYTES-k)-1 -: 8];
    end
  end

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    j_d         = j_q;
    msg_d       = msg_q;
    cw_d        = cw_q;
    cw_count_d  = cw_count_q;
    out_valid_d = out_valid_q;
    out_first_d = out_first_q;
    out_data_d  = out_data_q;

    case (state_q)
      ST_COLLECT: begin
        if (flush) begin
          idx_d = '0;
          msg_d = '0;
        end else if (in_valid) begin
          for (int i = 0; i < MSG_BYTES; i++) begin
            if (idx_q == IDX_W'(i)) msg_d[8*(MSG_BYTES-i)-1 -: 8] = in_data;
          end
          if (idx_q == IDX_W'(MSG_BYTES-1)) begin
            idx_d   = '0;
            state_d = ST_ENCODE;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end

      ST_ENCODE: begin
        // Byte 0 is loaded straight from the encoder so it is valid on EMIT entry.
        cw_d        = enc_cw;
        state_d     = ST_EMIT;
        out_valid_d = 1'b1;
        out_first_d = 1'b1;
        out_data_d  = enc_cw[CW_W-1 -: 8];
      end

      ST_EMIT: begin
        if (out_ready) begin
          if (j_q == J_W'(CW_BYTES-1)) begin
            state_d     = ST_COLLECT;
            j_d         = '0;
            cw_count_d  = cw_count_q + 16'd1;
            out_valid_d = 1'b0;
            out_first_d = 1'b0;
            out_data_d  = 8'h00;
          end else begin
            j_d         = j_next;
            out_first_d = 1'b0;
            out_data_d  = cw_byte_next;
          end
        end
      end

      default: state_d = ST_COLLECT;
    endcase

    busy_d = !((state_d == ST_COLLECT) && (idx_d == '0));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_COLLECT;
      idx_q       <= '0;
      j_q         <= '0;
      msg_q       <= '0;
      cw_q        <= '0;
      cw_count_q  <= '0;
      out_valid_q <= 1'b0;
      out_first_q <= 1'b0;
      out_data_q  <= 8'h00;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      j_q         <= j_d;
      msg_q       <= msg_d;
      cw_q        <= cw_d;
      cw_count_q  <= cw_count_d;
      out_valid_q <= out_valid_d;
      out_first_q <= out_first_d;
      out_data_q  <= out_data_d;
      busy_q      <= busy_d;
    end
  end

endmodule
